xbus_arbiter: RTL and testbench



---
 rtl/xbus_arbiter.sv | 149 ++++++++++++++
 tb/tb_xbus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xbus_arbiter.sv
// Round-robin arbiter sharing one blocking XBus channel among NUM_WR writers and one reader.
// A single holding register carries the granted word until it is read, abandoned, or timed out.
module xbus_arbiter #(
    parameter int NUM_WR        = 4,
    parameter int WIDTH         = 11,
    parameter int TIMEOUT_STEPS = 8,
    localparam int GW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1,
    localparam int CW = (TIMEOUT_STEPS > 0) ? $clog2(TIMEOUT_STEPS + 1) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    posedge_big_clk,
    input  logic [NUM_WR-1:0]       wr_req,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    output logic [NUM_WR-1:0]       wr_ack,
    input  logic                    rd_req,
    output logic                    rd_valid,
    output logic [WIDTH-1:0]        rd_data,
    output logic [GW-1:0]           grant_id,
    output logic                    busy,
    output logic                    timeout
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [GW-1:0]     last_q, last_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [NUM_WR-1:0] ack_q, ack_d;
    logic              timeout_q, timeout_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Round robin as two priority scans: writers above last first, then wrap to the rest.
    logic              found_hi, found_lo;
    logic [GW-1:0]     pick_hi, pick_lo;
    logic [WIDTH-1:0]  data_hi, data_lo;

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        data_hi  = '0;
        data_lo  = '0;
        for (int i = NUM_WR - 1; i >= 0; i--) begin
            if (wr_req[i]) begin
                if (GW'(i) > last_q) begin
                    found_hi = 1'b1;
                    pick_hi  = GW'(i);
                    data_hi  = wr_data[i*WIDTH +: WIDTH];
                end else begin
                    found_lo = 1'b1;
                    pick_lo  = GW'(i);
                    data_lo  = wr_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    logic req_granted;
    always_comb begin
        req_granted = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (grant_q == GW'(i)) req_granted = wr_req[i];
        end
    end

    logic step_hit;
    generate
        if (TIMEOUT_STEPS == 0) begin : g_no_timeout
            assign step_hit = 1'b0;
        end else begin : g_timeout
            // The strobe sampled now is the TIMEOUT_STEPS-th one once the count sits one short.
            assign step_hit = posedge_big_clk && (cnt_q >= CW'(TIMEOUT_STEPS - 1));
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        data_d    = data_q;
        ack_d     = '0;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found_hi || found_lo) begin
                    state_d = S_HOLD;
                    grant_d = found_hi ? pick_hi : pick_lo;
                    data_d  = found_hi ? data_hi : data_lo;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (rd_req) begin
                    for (int i = 0; i < NUM_WR; i++) ack_d[i] = (grant_q == GW'(i));
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else if (!req_granted) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else if (step_hit) begin
                    timeout_d = 1'b1;
                    last_d    = grant_q;
                    state_d   = S_IDLE;
                end else if (posedge_big_clk && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            last_q    <= GW'(NUM_WR - 1);
            grant_q   <= '0;
            data_q    <= '0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rd_valid = (state_q == S_HOLD);
    assign busy     = (state_q == S_HOLD);
    assign rd_data  = data_q;
    assign grant_id = grant_q;
    assign wr_ack   = ack_q;
    assign timeout  = timeout_q;

    a_ack_timeout_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !((|wr_ack) && timeout));
    a_release_single: assert property (@(posedge clk) disable iff (!rst_n)
        ((|wr_ack) || timeout) |=> !((|wr_ack) || timeout));

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter: transactional reference model compared every cycle,
// plus hand-computed expectations for each scenario.
module tb_xbus_arbiter;
    localparam int N  = 4;
    localparam int W  = 11;
    localparam int TS = 3;
    localparam int GW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           posedge_big_clk = 1'b0;
    logic [N-1:0]   wr_req = '0;
    logic [N*W-1:0] wr_data = '0;
    logic [N-1:0]   wr_ack;
    logic           rd_req = 1'b0;
    logic           rd_valid;
    logic [W-1:0]   rd_data;
    logic [GW-1:0]  grant_id;
    logic           busy;
    logic           timeout;

    xbus_arbiter #(.NUM_WR(N), .WIDTH(W), .TIMEOUT_STEPS(TS)) dut (
        .clk(clk), .rst_n(rst_n), .posedge_big_clk(posedge_big_clk),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .grant_id(grant_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: holding slot as (valid, data, owner), round robin by modular search.
    int           m_last  = N - 1;
    int           m_grant = 0;
    int           m_steps = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic [N-1:0] m_ack   = '0;
    bit           m_to    = 1'b0;

    initial begin : model
        int pick;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_last = N - 1; m_grant = 0; m_steps = 0;
                m_valid = 0; m_data = '0; m_ack = '0; m_to = 0;
            end else begin
                m_ack = '0;
                m_to  = 0;
                if (!m_valid) begin
                    pick = -1;
                    for (int k = 1; k <= N; k++)
                        if (pick < 0 && ((wr_req >> ((m_last + k) % N)) & 1) != 0)
                            pick = (m_last + k) % N;
                    if (pick >= 0) begin
                        m_valid = 1; m_grant = pick; m_steps = 0;
                        m_data = W'(wr_data >> (pick * W));
                    end
                end else if (rd_req) begin
                    m_ack = N'(1 << m_grant); m_last = m_grant; m_valid = 0;
                end else if (((wr_req >> m_grant) & 1) == 0) begin
                    m_last = m_grant; m_valid = 0;
                end else if (posedge_big_clk) begin
                    m_steps++;
                    if (m_steps == TS) begin
                        m_to = 1; m_last = m_grant; m_valid = 0;
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("cmp_rd_valid", rd_valid, m_valid);
            chk("cmp_busy", busy, m_valid);
            chk("cmp_rd_data", rd_data, m_data);
            chk("cmp_grant_id", grant_id, m_grant);
            chk("cmp_wr_ack", wr_ack, m_ack);
            chk("cmp_timeout", timeout, m_to);
        end
    end

    int cyc = 0;
    int ack_cnt[N];
    int to_cnt = 0;
    int strobes = 0;
    bit auto_drop = 1'b0;
    bit strb_en = 1'b0;

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++)
            if (((wr_ack >> i) & 1) != 0) ack_cnt[i]++;
        if (timeout) to_cnt++;
        if (auto_drop) wr_req = wr_req & ~wr_ack;
        posedge_big_clk = strb_en && (cyc % 5 == 4);
        if (posedge_big_clk && busy) strobes++;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        to_cnt = 0;
        strobes = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int rd_vals[$];
    int rd_cycs[$];
    int exp_rr[5] = '{1, 2, 3, 4, 1};
    bit seen;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_data", rd_data, 11'h000);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_wr_ack", wr_ack, 4'b0000);
        tick();

        // Single writer 2 sends 999, reader always ready.
        wr_data[2*W +: W] = 11'h3E7;
        wr_req = 4'b0100; rd_req = 1'b1; auto_drop = 1'b1;
        tick();
        chk("single_valid", rd_valid, 1'b1);
        chk("single_data", rd_data, 11'h3E7);
        chk("single_grant", grant_id, 2'd2);
        tick();
        chk("single_ack", wr_ack, 4'b0100);
        chk("single_valid_drop", rd_valid, 1'b0);
        tick();
        chk("single_idle", rd_valid, 1'b0);
        chk("single_ack_once", wr_ack, 4'b0000);
        rd_req = 1'b0;

        // Round robin from a fresh reset: 1,2,3,4,1 two cycles apart.
        do_reset();
        clear_counts();
        auto_drop = 1'b0;
        wr_data = {11'd4, 11'd3, 11'd2, 11'd1};
        wr_req = 4'hF; rd_req = 1'b1;
        for (int t = 0; t < 30 && rd_vals.size() < 5; t++) begin
            tick();
            if (rd_valid && rd_req) begin
                rd_vals.push_back(int'(rd_data));
                rd_cycs.push_back(cyc);
            end
        end
        chk("rr_reads", rd_vals.size(), 5);
        for (int i = 0; i < 5 && i < rd_vals.size(); i++) chk("rr_value", rd_vals[i], exp_rr[i]);
        for (int i = 1; i < 5 && i < rd_cycs.size(); i++) chk("rr_spacing", rd_cycs[i] - rd_cycs[i-1], 2);
        tick();
        wr_req = '0; rd_req = 1'b0;
        chk("rr_ack0", ack_cnt[0], 2);
        chk("rr_ack1", ack_cnt[1], 1);
        chk("rr_ack2", ack_cnt[2], 1);
        chk("rr_ack3", ack_cnt[3], 1);
        tick();

        // Writer 1 sends -999 bit-exact.
        wr_data[1*W +: W] = 11'h419;
        wr_req = 4'b0010; auto_drop = 1'b1;
        tick();
        chk("neg_data", rd_data, 11'h419);
        chk("neg_grant", grant_id, 2'd1);
        rd_req = 1'b1;
        tick();
        chk("neg_ack", wr_ack, 4'b0010);
        rd_req = 1'b0;
        tick();

        // Timeout after the 3rd strobe in HOLD; writer 1 goes next.
        clear_counts();
        auto_drop = 1'b0;
        wr_req = 4'b0011; cyc = 0; strb_en = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            tick();
            if (timeout) seen = 1'b1;
        end
        strb_en = 1'b0; posedge_big_clk = 1'b0;
        chk("to_seen", seen, 1'b1);
        chk("to_strobes", strobes, 3);
        chk("to_grant_w0", grant_id, 2'd0);
        chk("to_no_ack", ack_cnt[0] + ack_cnt[1], 0);
        chk("to_valid_drop", rd_valid, 1'b0);
        tick();
        chk("to_next_grant", grant_id, 2'd1);
        chk("to_next_valid", rd_valid, 1'b1);
        chk("to_pulse_once", to_cnt, 1);

        // Abort: writer 1 withdraws, no ack.
        wr_req = 4'b0000;
        tick();
        chk("abort_valid", rd_valid, 1'b0);
        chk("abort_no_ack", wr_ack, 4'b0000);
        chk("abort_no_to", timeout, 1'b0);

        // Drop coincides with read: transfer wins.
        wr_data[2*W +: W] = 11'h155;
        wr_req = 4'b0100;
        tick();
        chk("xfer_grant", grant_id, 2'd2);
        wr_req = 4'b0000; rd_req = 1'b1;
        tick();
        chk("xfer_ack", wr_ack, 4'b0100);
        chk("xfer_valid_drop", rd_valid, 1'b0);
        rd_req = 1'b0;
        tick();

        // Asynchronous reset mid-HOLD, then writer 0 has priority over writer 3.
        wr_req = 4'b1000;
        tick();
        chk("rstm_busy_before", busy, 1'b1);
        wr_req = 4'b1001;
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_valid", rd_valid, 1'b0);
        chk("rstm_busy", busy, 1'b0);
        chk("rstm_ack", wr_ack, 4'b0000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstm_w0_first", grant_id, 2'd0);
        chk("rstm_valid_after", rd_valid, 1'b1);
        wr_req = '0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
